// File: rtl/spi_memory_burst.sv
// SPI-slave memory with burst access and a frame-error flag.
// A command frame is ADDR_W address bits followed by one R/W bit (1 = read),
// MSB first. Data words of DATA_W bits follow, and the address auto-increments
// (modulo DEPTH) for as long as CS stays low. SPI mode 0 or 3 is chosen with CPOL.
// In both modes the slave samples on the SCLK rise and shifts on the fall.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   sclk_pin, cs_pin      asynchronous SPI clock and active-low chip select
//   mosi_pin              serial data in
//   miso_pin, miso_en     serial data out and its output enable (external tristate)
//   busy                  transaction in progress (synchronised CS low)
//   frame_error           one-clk pulse when CS rises mid-command or mid-word
//   word_count            data words completed in the current/last transaction
module spi_memory_burst #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk_pin,
  input  logic              cs_pin,
  input  logic              mosi_pin,
  output logic              miso_pin,
  output logic              miso_en,
  output logic              busy,
  output logic              frame_error,
  output logic [ADDR_W-1:0] word_count
);

  localparam int unsigned MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
  localparam int unsigned TOP      = SYNC_STAGES - 1;

  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic              SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_LOAD,
    RD_DATA,
    WR_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] shreg;
  logic              wr_pend;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sclk_rise_c;
  logic              sclk_fall_c;
  logic              cs_rise_c;
  logic              cs_fall_c;
  logic              mosi_c;
  logic              rise_in_frame_c;
  logic              last_bit_c;
  logic [CNT_W-1:0]  bit_cnt_nxt_c;
  logic [ADDR_W-1:0] addr_inc_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] rd_next_c;

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
    return MEM_AW'(a);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_reduce(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % DEPTH);
  endfunction

  // Input synchronisers. CS resets to the "low" value so a CS already held low
  // at reset release is not mistaken for a new falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= SCLK_IDLE;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[TOP-1:0], sclk_pin};
      cs_sync   <= {cs_sync[TOP-1:0], cs_pin};
      mosi_sync <= {mosi_sync[TOP-1:0], mosi_pin};
      sclk_prev <= sclk_sync[TOP];
      cs_prev   <= cs_sync[TOP];
    end
  end

  // Edge pulses and the bit-counter outcome of this clock's SCLK edge, which a
  // coincident CS rise needs in order to decide on a frame error.
  always_comb begin
    sclk_rise_c     = sclk_sync[TOP] & ~sclk_prev;
    sclk_fall_c     = ~sclk_sync[TOP] & sclk_prev;
    cs_rise_c       = cs_sync[TOP] & ~cs_prev;
    cs_fall_c       = ~cs_sync[TOP] & cs_prev;
    mosi_c          = mosi_sync[TOP];
    rise_in_frame_c = sclk_rise_c && (state == CMD || state == RD_DATA || state == WR_DATA);
    last_bit_c      = rise_in_frame_c &&
                      (bit_cnt == ((state == CMD) ? CMD_LAST : DATA_LAST));
    bit_cnt_nxt_c   = bit_cnt;
    if (rise_in_frame_c) begin
      bit_cnt_nxt_c = last_bit_c ? '0 : bit_cnt + CNT_W'(1);
    end
    addr_inc_c      = (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
    rd_word_c       = mem[mem_idx(addr)];
    rd_next_c       = mem[mem_idx(addr_inc_c)];
  end

  // Transaction FSM. Falls are only acted on in RD_DATA, so the leading fall of
  // a mode-3 frame (idle high) never shifts anything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      addr        <= '0;
      shreg       <= '0;
      wr_pend     <= 1'b0;
      miso_pin    <= 1'b0;
      miso_en     <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      word_count  <= '0;
    end else begin
      frame_error <= 1'b0;
      wr_pend     <= 1'b0;
      bit_cnt     <= bit_cnt_nxt_c;

      // Commit of a completed write word, one clk after its last sampled bit.
      if (wr_pend) begin
        addr       <= addr_inc_c;
        word_count <= word_count + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state      <= CMD;
            bit_cnt    <= '0;
            word_count <= '0;
            busy       <= 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise_c) begin
            if (last_bit_c) begin
              addr  <= addr_reduce(addr);
              state <= mosi_c ? RD_LOAD : WR_DATA;
            end else begin
              addr  <= ADDR_W'({addr, mosi_c});
            end
          end
        end
        RD_LOAD: begin
          shreg   <= rd_word_c;
          miso_en <= 1'b1;
          state   <= RD_DATA;
        end
        RD_DATA: begin
          if (sclk_fall_c) begin
            miso_pin <= shreg[DATA_W-1];
            shreg    <= {shreg[DATA_W-2:0], 1'b0};
          end
          // Preload the next word so its MSB goes out on the very next fall.
          if (last_bit_c) begin
            addr       <= addr_inc_c;
            word_count <= word_count + ADDR_W'(1);
            shreg      <= rd_next_c;
          end
        end
        WR_DATA: begin
          if (sclk_rise_c) begin
            shreg <= {shreg[DATA_W-2:0], mosi_c};
            if (last_bit_c) begin
              wr_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // CS rise wins over the state update but the same-clk SCLK edge still counts.
      if (cs_rise_c) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        miso_en     <= 1'b0;
        miso_pin    <= 1'b0;
        busy        <= 1'b0;
        frame_error <= (bit_cnt_nxt_c != '0);
      end
    end
  end

  // Word storage; shreg holds the finished word while wr_pend is high.
  always_ff @(posedge clk) begin
    if (wr_pend) begin
      mem[mem_idx(addr)] <= shreg;
    end
  end

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: a mode-0 and a mode-3 instance share one SPI
// master, selected by sel. Expected data comes from a table and from a flat
// array model of the memory.
module tb_spi_memory_burst;

  localparam int CLK_P = 10;
  localparam int HALF  = 80;
  localparam int GAP   = 4 * HALF;

  logic clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  logic reset_n, sclk, cs, mosi, sel;
  logic sclk0, cs0, sclk1, cs1;
  logic miso0, en0, busy0, fe0, miso1, en1, busy1, fe1;
  logic [6:0] wc0, wc1;
  logic miso, en, busy;
  logic [6:0] wc;

  assign sclk0 = sel ? 1'b0 : sclk;
  assign cs0   = sel ? 1'b1 : cs;
  assign sclk1 = sel ? sclk : 1'b1;
  assign cs1   = sel ? cs : 1'b1;
  assign miso  = sel ? miso1 : miso0;
  assign en    = sel ? en1 : en0;
  assign busy  = sel ? busy1 : busy0;
  assign wc    = sel ? wc1 : wc0;

  spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .CPOL(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .sclk_pin(sclk0), .cs_pin(cs0), .mosi_pin(mosi),
    .miso_pin(miso0), .miso_en(en0), .busy(busy0), .frame_error(fe0), .word_count(wc0)
  );

  spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .CPOL(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi),
    .miso_pin(miso1), .miso_en(en1), .busy(busy1), .frame_error(fe1), .word_count(wc1)
  );

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  logic [7:0] ref_mem [128];

  logic [3:0][7:0] rdat;
  logic en_cmd_or, en_data_or, en_data_and;
  logic post_busy, post_en, post_miso;
  logic [6:0] post_wc;

  always @(negedge clk) if (fe0 | fe1) fe_cnt++;

  typedef struct {
    bit              s;
    logic [6:0]      a;
    bit              rd;
    int              cbits;
    int              nw;
    int              pbits;
    logic [3:0][7:0] d;
    int              wc;
    int              fe;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One SCLK period: shift-edge (fall) with new MOSI, then sample-edge (rise).
  task automatic spi_bit(input logic b, input bit cs_up, output logic r, output logic e);
    sclk = 1'b0;
    mosi = b;
    #HALF;
    sclk = 1'b1;
    if (cs_up) cs = 1'b1;
    r = miso;
    e = en;
    #HALF;
  endtask

  task automatic txn(input bit s, input logic [6:0] a, input bit rd, input int cbits,
                     input int nw, input int pbits, input logic [3:0][7:0] wd,
                     input bit cs_last, input int gap);
    logic [7:0] cmd;
    logic r, e;
    bit lastb;
    sclk = s;
    sel  = s;
    mosi = 1'b0;
    #(4 * CLK_P);
    fe_cnt = 0;
    en_cmd_or = 1'b0;
    en_data_or = 1'b0;
    en_data_and = 1'b1;
    rdat = '0;
    cs = 1'b0;
    #HALF;
    cmd = {a, rd};
    for (int i = 0; i < cbits; i++) begin
      spi_bit(cmd[7-i], 1'b0, r, e);
      en_cmd_or |= e;
    end
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) begin
        lastb = cs_last && (w == nw - 1) && (b == 7);
        spi_bit(wd[w][7-b], lastb, r, e);
        rdat[w][7-b] = r;
        en_data_or  |= e;
        en_data_and &= e;
      end
    end
    for (int b = 0; b < pbits; b++) spi_bit(wd[nw][7-b], 1'b0, r, e);
    if (!cs_last) begin
      if (!s) begin
        sclk = 1'b0;
        #HALF;
      end
      cs = 1'b1;
    end
    #60;
    post_busy = busy;
    post_en   = en;
    post_miso = miso;
    post_wc   = wc;
    #(gap - 60 - 4 * CLK_P);
  endtask

  task automatic check_txn(input string tag, input bit rd, input int nw,
                           input logic [3:0][7:0] exp, input int exp_wc, input int exp_fe);
    for (int w = 0; w < nw; w++) begin
      if (rd) chk($sformatf("%s rd_word%0d", tag, w), 32'(rdat[w]), 32'(exp[w]));
    end
    chk($sformatf("%s word_count", tag), 32'(post_wc), 32'(exp_wc));
    chk($sformatf("%s frame_error_pulses", tag), 32'(fe_cnt), 32'(exp_fe));
    chk($sformatf("%s idle_outputs", tag), {29'b0, post_busy, post_en, post_miso}, 32'h0);
    chk($sformatf("%s miso_en_in_cmd", tag), 32'(en_cmd_or), 32'h0);
    if (nw > 0) chk($sformatf("%s miso_en_in_data", tag), {30'b0, en_data_or, en_data_and},
                    rd ? 32'h3 : 32'h0);
  endtask

  initial begin
    logic [3:0][7:0] d;
    logic [3:0][7:0] e;
    logic [6:0] a;
    bit rd;
    int nw;
    logic r, en_s;

    reset_n = 1'b0;
    sel = 1'b0;
    sclk = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mode0", {21'b0, miso0, en0, busy0, fe0, wc0}, 32'h0);
    chk("reset_mode3", {21'b0, miso1, en1, busy1, fe1, wc1}, 32'h0);
    reset_n = 1'b1;
    #(10 * CLK_P);

    // Fill the mode-0 memory so every later read has a known value.
    for (int k = 0; k < 32; k++) begin
      for (int w = 0; w < 4; w++) d[w] = 8'($urandom);
      txn(1'b0, 7'(4 * k), 1'b0, 8, 4, 0, d, 1'b0, GAP);
      for (int w = 0; w < 4; w++) ref_mem[4 * k + w] = d[w];
      check_txn($sformatf("init%0d", k), 1'b0, 4, d, 4, 0);
    end

    tbl[0]  = '{0, 7'h01, 0, 8, 1, 0, 32'h00000055, 1, 0};
    tbl[1]  = '{0, 7'h01, 1, 8, 1, 0, 32'h00000055, 1, 0};
    tbl[2]  = '{0, 7'h7E, 0, 8, 3, 0, 32'h00332211, 3, 0};
    tbl[3]  = '{0, 7'h7E, 1, 8, 3, 0, 32'h00332211, 3, 0};
    tbl[4]  = '{0, 7'h00, 1, 8, 1, 0, 32'h00000033, 1, 0};
    tbl[5]  = '{0, 7'h05, 0, 8, 1, 0, 32'h000000AA, 1, 0};
    tbl[6]  = '{0, 7'h05, 0, 8, 0, 4, 32'h0000000F, 0, 1};
    tbl[7]  = '{0, 7'h05, 1, 8, 1, 0, 32'h000000AA, 1, 0};
    tbl[8]  = '{0, 7'h03, 1, 3, 0, 0, 32'h00000000, 0, 1};
    tbl[9]  = '{1, 7'h02, 0, 8, 1, 0, 32'h000000C3, 1, 0};
    tbl[10] = '{1, 7'h02, 1, 8, 1, 0, 32'h000000C3, 1, 0};

    for (int v = 0; v < 11; v++) begin
      txn(tbl[v].s, tbl[v].a, tbl[v].rd, tbl[v].cbits, tbl[v].nw, tbl[v].pbits,
          tbl[v].d, 1'b0, GAP);
      check_txn($sformatf("vec%0d", v), tbl[v].rd, tbl[v].nw, tbl[v].d, tbl[v].wc, tbl[v].fe);
      if (!tbl[v].s && !tbl[v].rd && tbl[v].cbits == 8)
        for (int w = 0; w < tbl[v].nw; w++) ref_mem[(int'(tbl[v].a) + w) % 128] = tbl[v].d[w];
    end

    // Random bursts on the mode-0 instance against the array model.
    for (int t = 0; t < 12; t++) begin
      a  = 7'($urandom_range(0, 127));
      rd = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 4);
      for (int w = 0; w < 4; w++) begin
        d[w] = 8'($urandom);
        e[w] = rd ? ref_mem[(int'(a) + w) % 128] : d[w];
      end
      txn(1'b0, a, rd, 8, nw, 0, d, 1'b0, GAP);
      check_txn($sformatf("rand%0d", t), rd, nw, e, nw, 0);
      if (!rd) for (int w = 0; w < nw; w++) ref_mem[(int'(a) + w) % 128] = d[w];
    end

    // CS rises together with the final sample edge: the word must still land.
    d = 32'h0000006E;
    txn(1'b0, 7'h20, 1'b0, 8, 1, 0, d, 1'b1, GAP);
    check_txn("cs_coincident_wr", 1'b0, 1, d, 1, 0);
    ref_mem[32] = 8'h6E;
    txn(1'b0, 7'h20, 1'b1, 8, 1, 0, '0, 1'b0, GAP);
    check_txn("cs_coincident_rd", 1'b1, 1, d, 1, 0);

    // Reset in the middle of the second word of a two-word write.
    sclk = 1'b0;
    sel = 1'b0;
    #(4 * CLK_P);
    fe_cnt = 0;
    cs = 1'b0;
    #HALF;
    d = {8'h0, 8'h0, 8'h5C, 8'h9A};
    for (int i = 0; i < 8; i++) spi_bit(i < 7 ? 1'(7'h10 >> (6 - i)) : 1'b0, 1'b0, r, en_s);
    for (int b = 0; b < 8; b++) spi_bit(d[0][7-b], 1'b0, r, en_s);
    for (int b = 0; b < 4; b++) spi_bit(d[1][7-b], 1'b0, r, en_s);
    chk("pre_reset_word_count", 32'(wc0), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {21'b0, miso0, en0, busy0, fe0, wc0}, 32'h0);
    #(3 * CLK_P);
    reset_n = 1'b1;
    for (int b = 0; b < 8; b++) spi_bit(1'b1, 1'b0, r, en_s);
    chk("ignored_after_reset", {24'b0, busy0, wc0}, 32'h0);
    sclk = 1'b0;
    #HALF;
    cs = 1'b1;
    #GAP;
    chk("reset_no_frame_error", 32'(fe_cnt), 32'h0);
    ref_mem[16] = 8'h9A;
    e = {8'h0, 8'h0, ref_mem[17], ref_mem[16]};
    txn(1'b0, 7'h10, 1'b1, 8, 2, 0, '0, 1'b0, GAP);
    check_txn("after_reset_rd", 1'b1, 2, e, 2, 0);

    // Back-to-back reads with CS high for two SCLK periods.
    e = {8'h0, ref_mem[0], ref_mem[127], ref_mem[126]};
    txn(1'b0, 7'h7E, 1'b1, 8, 3, 0, '0, 1'b0, 4 * HALF);
    check_txn("b2b_first", 1'b1, 3, e, 3, 0);
    e = {8'h0, 8'h0, 8'h0, ref_mem[5]};
    txn(1'b0, 7'h05, 1'b1, 8, 1, 0, '0, 1'b0, 4 * HALF);
    check_txn("b2b_second", 1'b1, 1, e, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
